// File: rtl/data_mem_lsu.sv
// data_mem_lsu
//   Load/store unit sitting between the multi-cycle RV32I datapath and the
//   byte-lane data RAM. Takes one request per valid/ready handshake, screens it
//   for illegal func3, misalignment and out-of-range address, drives the RAM
//   for a single ACCESS cycle and returns the registered result through a held
//   valid/ready response. Faulting requests never reach the RAM.
//
// Ports
//   clk, rst_n                     clock (rising edge), async active-low reset
//   req_valid/req_ready            request handshake (ready only in IDLE)
//   req_we/addr/wdata/func3        request payload
//   rsp_valid/rsp_ready            response handshake
//   rsp_rdata/rsp_fault            extended load data / rejection flag
//   fault_cnt                      saturating count of rejected requests
//   ram_we/addr/wData/func3        RAM control, addr/data/func3 from the latch
//   ram_rData                      RAM combinational read data (pre-extended)
//
// state  | meaning
// IDLE   | waiting for a request, req_ready high
// ACCESS | one cycle driving the RAM, read data captured at its closing edge
// RESP   | response held until rsp_ready
module data_mem_lsu #(
  parameter logic [31:0] MEM_BYTES = 32'h40,
  parameter int unsigned FCNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [2:0]        req_func3,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_fault,
  output logic [FCNT_W-1:0] fault_cnt,
  output logic              ram_we,
  output logic [31:0]       ram_addr,
  output logic [31:0]       ram_wData,
  output logic [2:0]        ram_func3,
  input  logic [31:0]       ram_rData
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic [31:0]         addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [2:0]          func3_q, func3_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [31:0]         rsp_rdata_q, rsp_rdata_d;
  logic                rsp_fault_q, rsp_fault_d;
  logic [FCNT_W-1:0]   fault_cnt_q, fault_cnt_d;

  logic                req_fire;
  logic                bad_func3;
  logic                misaligned;
  logic                out_of_range;
  logic                req_fault;

  // Request screening works on the live request so the decision is made at the
  // accept edge and a rejected request goes straight to RESP.
  always_comb begin
    bad_func3 = 1'b0;
    if (req_we) begin
      bad_func3 = (req_func3 >= 3'b011);
    end else begin
      bad_func3 = (req_func3 == 3'b011) || (req_func3 == 3'b110) ||
                  (req_func3 == 3'b111);
    end
    // func3[1:0] encodes size for both loads and stores: 01 half, 10 word.
    misaligned   = ((req_func3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_func3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    out_of_range = (req_addr >= MEM_BYTES);
    req_fault    = bad_func3 || misaligned || out_of_range;
  end

  assign req_ready = (state_q == IDLE);
  assign req_fire  = req_valid && req_ready;

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    func3_d     = func3_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_fault_d = rsp_fault_q;
    fault_cnt_d = fault_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (req_fire) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          func3_d = req_func3;
          if (req_fault) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
            rsp_fault_d = 1'b1;
            if (fault_cnt_q != {FCNT_W{1'b1}}) begin
              fault_cnt_d = fault_cnt_q + {{(FCNT_W-1){1'b0}}, 1'b1};
            end
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = we_q ? 32'h0 : ram_rData;
        rsp_fault_d = 1'b0;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      func3_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_fault_q <= 1'b0;
      fault_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      func3_q     <= func3_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_fault_q <= rsp_fault_d;
      fault_cnt_q <= fault_cnt_d;
    end
  end

  // Write enable is decoded from state so a reset during ACCESS kills it at once.
  assign ram_we    = (state_q == ACCESS) && we_q;
  assign ram_addr  = addr_q;
  assign ram_wData = wdata_q;
  assign ram_func3 = func3_q;

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_fault = rsp_fault_q;
  assign fault_cnt = fault_cnt_q;

endmodule
